lsu_mem_ctrl: RTL and testbench
===============================

# lsu_mem_ctrl

Load/store memory controller for the RISC-V core: it executes the load/store commands produced by instruction decode (funct3-encoded lb/lh/lw/lbu/lhu, sb/sh/sw) against a word-wide, handshaked data-memory bus. It generates byte strobes, lane shifts and sign/zero extension. It splits any access that crosses a 32-bit word boundary into two bus beats. It sits between the core's execute stage and data memory, and returns one response per accepted command.

## Interface
- `ADDR_W`, default 32: byte-address width; all address arithmetic is modulo 2^ADDR_W.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: command present.
- `req_ready` out 1: command accepted on `req_valid && req_ready`.
- `req_store` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: load 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu; store 000 sb, 001 sh, 010 sw.
- `req_addr` in ADDR_W: byte address.
- `req_wdata` in 32: store data, LSB-aligned.
- `rsp_valid` out 1: one-cycle response pulse, no backpressure.
- `rsp_rdata` out 32: extended load result; 0 for stores and errors.
- `rsp_err` out 1: illegal funct3, valid with `rsp_valid`.
- `mem_req` out 1: bus beat request.
- `mem_gnt` in 1: beat accepted on `mem_req && mem_gnt`.
- `mem_we` out 1: write beat.
- `mem_addr` out ADDR_W: word-aligned address, bits [1:0] = 00.
- `mem_wdata` out 32: lane-positioned write data; unused lanes 0.
- `mem_wstrb` out 4: byte enables; 0000 on reads.
- `mem_rvalid` in 1: read data valid, at least 1 cycle after the grant.
- `mem_rdata` in 32: read data.

## Operation
- FSM states: IDLE, REQ1, WAIT1, REQ2, WAIT2, RESP.
- `req_ready = (state==IDLE) && !rst`.
- On accept, the block latches the command, computes `off = addr[1:0]` and size (1/2/4 bytes), and sets `split = off+size > 4`.
- Illegal funct3 (load 011/110/111, store 011–111) goes to RESP with `rsp_err=1`. No bus activity.
- Otherwise the FSM goes to REQ1.
- REQ1: `mem_req=1`, `mem_addr = addr & ~3`. The FSM holds until grant. On grant:
  - load → WAIT1;
  - store → REQ2 if split, else RESP.
- WAIT1: on `mem_rvalid` the block captures beat0 data, then goes to REQ2 if split, else RESP.
- REQ2: `mem_addr = (addr & ~3) + 4`, wrapping at 2^ADDR_W. On grant:
  - load → WAIT2;
  - store → RESP.
- WAIT2: on `mem_rvalid` the block captures beat1 data and goes to RESP.
- RESP: `rsp_valid=1` for exactly one cycle, then IDLE.
- Store lanes:
  - 8-bit mask `m = {size ones} << off`;
  - 64-bit data `d = wdata_masked << 8*off`;
  - beat0 uses `m[3:0]`/`d[31:0]`, beat1 uses `m[7:4]`/`d[63:32]`.
- Load data: `{beat1, beat0} >> 8*off`. The low byte/half/word is then sign-extended (lb, lh) or zero-extended (lbu, lhu).
- `mem_rvalid` is ignored outside WAIT1/WAIT2.
- `mem_we`, `mem_wstrb`, `mem_wdata` and `mem_addr` hold stable while `mem_req=1` and no grant.

## Timing
- All outputs are registered, except `req_ready`.
- Reset values:
  - `mem_req`, `mem_we`, `rsp_valid`, `rsp_err` = 0;
  - `mem_wstrb` = 0000;
  - `mem_addr`, `mem_wdata`, `rsp_rdata` = 0;
  - state = IDLE.
- `rst` mid-operation: the next cycle is IDLE with `mem_req=0` and no response. A late `mem_rvalid` is ignored.
- Aligned load, grant at first request, rvalid 1 cycle after grant:
  - accept at cycle 0;
  - `mem_req` at cycle 1;
  - `mem_rvalid` at cycle 2;
  - `rsp_valid` at cycle 3.
- Aligned store: accept at cycle 0, `mem_req` at cycle 1, `rsp_valid` at cycle 2.
- Each split beat adds one request cycle, plus the read wait for loads.
- Error: `rsp_valid` the cycle after accept.
- Throughput: one command in flight. The next accept is possible in the cycle after RESP.

## Test plan
- lw at 0x1000, `mem_rdata` 0xDEADBEEF → single beat at addr 0x1000, wstrb 0000; `rsp_rdata` 0xDEADBEEF, `rsp_valid` at cycle 3.
- lb at 0x3002, `mem_rdata` 0x00F00000 → `rsp_rdata` 0xFFFFFFF0. lbu with the same stimulus → 0x000000F0.
- lhu at 0x2003, beats 0x11223344 and 0x55667788 → beat0 at 0x2000, beat1 at 0x2004; `rsp_rdata` 0x00008811.
- sw at 0x1001, wdata 0xAABBCCDD, `mem_gnt` low for 2 cycles on beat0 → outputs stable while stalled:
  - beat0: addr 0x1000, wstrb 1110, wdata 0xBBCCDD00;
  - beat1: addr 0x1004, wstrb 0001, wdata 0x000000AA.
- Load with funct3 110 → no `mem_req`; `rsp_valid=1`, `rsp_err=1`, `rsp_rdata=0` the cycle after accept.
- `rst` pulsed while in WAIT1, with `mem_rvalid` the following cycle → no `rsp_valid`, `mem_req=0`, `req_ready=1` after reset deasserts.

Source files
------------

// File: rtl/lsu_mem_ctrl_if.sv
// Core-side command/response and data-memory bus signals of the load/store controller.
// The controller takes the slave modport; the core/memory environment takes master.
interface lsu_mem_ctrl_if #(
    parameter int unsigned ADDR_W = 32
) ();
    logic              req_valid;
    logic              req_ready;
    logic              req_store;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;

    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;

    logic              mem_req;
    logic              mem_gnt;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_wstrb;
    logic              mem_rvalid;
    logic [31:0]       mem_rdata;

    modport slave (
        input  req_valid, req_store, req_funct3, req_addr, req_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
    );

    modport master (
        output req_valid, req_store, req_funct3, req_addr, req_wdata,
        output mem_gnt, mem_rvalid, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
    );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// RISC-V load/store controller: byte strobes, lane shifting, sign/zero extension and
// splitting of word-crossing accesses into two bus beats. One command in flight.
module lsu_mem_ctrl #(
    parameter int unsigned ADDR_W = 32
) (
    input logic           clk,
    input logic           rst,
    lsu_mem_ctrl_if.slave bus
);
    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StReq1  = 3'd1;
    localparam logic [2:0] StWait1 = 3'd2;
    localparam logic [2:0] StReq2  = 3'd3;
    localparam logic [2:0] StWait2 = 3'd4;
    localparam logic [2:0] StResp  = 3'd5;

    logic [2:0]        state_q, state_d;
    logic              store_q, store_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [1:0]        off_q, off_d;
    logic              split_q, split_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [7:0]        strb_q, strb_d;
    logic [63:0]       wdat_q, wdat_d;
    logic [31:0]       beat0_q, beat0_d;

    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic [3:0]        mem_wstrb_q, mem_wstrb_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_err_q, rsp_err_d;
    logic [31:0]       rsp_rdata_q, rsp_rdata_d;

    logic [1:0]  req_off;
    logic [2:0]  req_size;
    logic [3:0]  req_ones;
    logic [31:0] req_wmask;
    logic        req_illegal;
    logic        req_split;
    logic [7:0]  req_strb;
    logic [63:0] req_wdat;

    always_comb begin
        req_off = bus.req_addr[1:0];
        case (bus.req_funct3[1:0])
            2'b00:   begin req_size = 3'd1; req_ones = 4'b0001; req_wmask = 32'h0000_00FF; end
            2'b01:   begin req_size = 3'd2; req_ones = 4'b0011; req_wmask = 32'h0000_FFFF; end
            default: begin req_size = 3'd4; req_ones = 4'b1111; req_wmask = 32'hFFFF_FFFF; end
        endcase
        if (bus.req_store) begin
            req_illegal = bus.req_funct3 > 3'b010;
        end else begin
            req_illegal = (bus.req_funct3[1:0] == 2'b11) || (bus.req_funct3 == 3'b110);
        end
        req_split = ({1'b0, req_off} + req_size) > 3'd4;
        req_strb  = {4'b0000, req_ones} << req_off;
        req_wdat  = {32'h0, bus.req_wdata & req_wmask} << {req_off, 3'b000};
    end

    // Beat1 occupies the upper word, so a right shift realigns the addressed bytes to bit 0.
    logic [63:0] ld_raw;
    logic [31:0] ld_shift;
    logic [31:0] ld_ext;

    always_comb begin
        ld_raw   = (state_q == StWait2) ? {bus.mem_rdata, beat0_q} : {32'h0, bus.mem_rdata};
        ld_shift = 32'(ld_raw >> {off_q, 3'b000});
        case (funct3_q)
            3'b000:  ld_ext = {{24{ld_shift[7]}}, ld_shift[7:0]};
            3'b001:  ld_ext = {{16{ld_shift[15]}}, ld_shift[15:0]};
            3'b010:  ld_ext = ld_shift;
            3'b100:  ld_ext = {24'h0, ld_shift[7:0]};
            3'b101:  ld_ext = {16'h0, ld_shift[15:0]};
            default: ld_ext = 32'h0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        store_d     = store_q;
        funct3_d    = funct3_q;
        off_d       = off_q;
        split_d     = split_q;
        base_d      = base_q;
        strb_d      = strb_q;
        wdat_d      = wdat_q;
        beat0_d     = beat0_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = mem_wstrb_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = 32'h0;

        case (state_q)
            StIdle: begin
                if (bus.req_valid) begin
                    store_d  = bus.req_store;
                    funct3_d = bus.req_funct3;
                    off_d    = req_off;
                    split_d  = req_split;
                    base_d   = {bus.req_addr[ADDR_W-1:2], 2'b00};
                    strb_d   = req_strb;
                    wdat_d   = req_wdat;
                    if (req_illegal) begin
                        state_d     = StResp;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end else begin
                        state_d     = StReq1;
                        mem_req_d   = 1'b1;
                        mem_we_d    = bus.req_store;
                        mem_addr_d  = {bus.req_addr[ADDR_W-1:2], 2'b00};
                        mem_wdata_d = bus.req_store ? req_wdat[31:0] : 32'h0;
                        mem_wstrb_d = bus.req_store ? req_strb[3:0] : 4'b0000;
                    end
                end
            end
            StReq1: begin
                if (bus.mem_gnt) begin
                    mem_req_d = 1'b0;
                    if (!store_q) begin
                        state_d = StWait1;
                    end else if (split_q) begin
                        state_d     = StReq2;
                        mem_req_d   = 1'b1;
                        mem_addr_d  = base_q + ADDR_W'(4);
                        mem_wdata_d = wdat_q[63:32];
                        mem_wstrb_d = strb_q[7:4];
                    end else begin
                        state_d     = StResp;
                        rsp_valid_d = 1'b1;
                    end
                end
            end
            StWait1: begin
                if (bus.mem_rvalid) begin
                    beat0_d = bus.mem_rdata;
                    if (split_q) begin
                        state_d     = StReq2;
                        mem_req_d   = 1'b1;
                        mem_we_d    = 1'b0;
                        mem_addr_d  = base_q + ADDR_W'(4);
                        mem_wdata_d = 32'h0;
                        mem_wstrb_d = 4'b0000;
                    end else begin
                        state_d     = StResp;
                        rsp_valid_d = 1'b1;
                        rsp_rdata_d = ld_ext;
                    end
                end
            end
            StReq2: begin
                if (bus.mem_gnt) begin
                    mem_req_d = 1'b0;
                    if (store_q) begin
                        state_d     = StResp;
                        rsp_valid_d = 1'b1;
                    end else begin
                        state_d = StWait2;
                    end
                end
            end
            StWait2: begin
                if (bus.mem_rvalid) begin
                    state_d     = StResp;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = ld_ext;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            store_q     <= 1'b0;
            funct3_q    <= 3'b000;
            off_q       <= 2'b00;
            split_q     <= 1'b0;
            base_q      <= '0;
            strb_q      <= 8'h0;
            wdat_q      <= 64'h0;
            beat0_q     <= 32'h0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'h0;
            mem_wstrb_q <= 4'b0000;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            store_q     <= store_d;
            funct3_q    <= funct3_d;
            off_q       <= off_d;
            split_q     <= split_d;
            base_q      <= base_d;
            strb_q      <= strb_d;
            wdat_q      <= wdat_d;
            beat0_q     <= beat0_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign bus.req_ready = (state_q == StIdle) && !rst;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_wstrb = mem_wstrb_q;
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Scoreboard bench for lsu_mem_ctrl: expected beats and responses are queued at issue time
// and checked by independent memory and response monitors.
module tb_lsu_mem_ctrl;
    logic clk;
    logic rst;
    int   checks;
    int   failures;
    int   cyc;
    int   acc_cyc;

    lsu_mem_ctrl_if #(.ADDR_W(32)) bus ();

    lsu_mem_ctrl #(.ADDR_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } beat_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic [31:0] lat;
    } rsp_t;

    beat_t       exp_beat[$];
    rsp_t        exp_rsp[$];
    logic [31:0] rd_q[$];
    beat_t       cur;
    bit          in_beat;
    bit          rd_pending;
    bit          no_auto_rv;
    bit          force_rv;
    int          stall_cnt;
    logic [31:0] rd_next;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Memory model and beat monitor: decides grants at negedge, returns read data a cycle later.
    initial begin
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = 32'h0;
        forever begin
            @(negedge clk);
            bus.mem_rvalid = 1'b0;
            if (rd_pending) begin
                bus.mem_rvalid = 1'b1;
                bus.mem_rdata  = rd_next;
                rd_pending     = 1'b0;
            end else if (force_rv) begin
                bus.mem_rvalid = 1'b1;
                bus.mem_rdata  = 32'h1234_5678;
            end
            bus.mem_gnt = 1'b0;
            if (bus.mem_req) begin
                if (!in_beat) begin
                    if (exp_beat.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_beat: got addr %h we %b expected no request",
                                 bus.mem_addr, bus.mem_we);
                        cur = '{bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_wstrb};
                    end else begin
                        cur = exp_beat.pop_front();
                    end
                    in_beat = 1'b1;
                end
                chk("mem_we", {31'h0, bus.mem_we}, {31'h0, cur.we});
                chk("mem_addr", bus.mem_addr, cur.addr);
                chk("mem_wdata", bus.mem_wdata, cur.wdata);
                chk("mem_wstrb", {28'h0, bus.mem_wstrb}, {28'h0, cur.wstrb});
                if (stall_cnt > 0) begin
                    stall_cnt--;
                end else begin
                    bus.mem_gnt = 1'b1;
                    in_beat     = 1'b0;
                    if (!bus.mem_we && !no_auto_rv) begin
                        rd_pending = 1'b1;
                        rd_next    = (rd_q.size() > 0) ? rd_q.pop_front() : 32'h0;
                    end
                end
            end
        end
    end

    // Response monitor
    initial begin
        rsp_t e;
        forever begin
            @(negedge clk);
            if (bus.rsp_valid) begin
                if (exp_rsp.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_rsp: got rdata %h err %b expected no response",
                             bus.rsp_rdata, bus.rsp_err);
                end else begin
                    e = exp_rsp.pop_front();
                    chk("rsp_rdata", bus.rsp_rdata, e.rdata);
                    chk("rsp_err", {31'h0, bus.rsp_err}, {31'h0, e.err});
                    chk("rsp_latency", 32'(cyc - acc_cyc), e.lat);
                end
            end
        end
    end

    task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input bit want_rsp, input logic [31:0] exp_rd,
                         input logic exp_err, input int lat);
        int n;
        if (want_rsp) exp_rsp.push_back('{exp_rd, exp_err, 32'(lat)});
        bus.req_valid  = 1'b1;
        bus.req_store  = st;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wd;
        n = 0;
        forever begin
            @(negedge clk);
            if (bus.req_ready) break;
            n++;
            if (n > 50) begin
                checks++;
                failures++;
                $display("FAIL accept_timeout: got req_ready 0 expected 1 within 50 cycles");
                break;
            end
        end
        acc_cyc = cyc;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            #1;
            if (exp_rsp.size() == 0 && exp_beat.size() == 0 && !in_beat && !rd_pending) break;
            n++;
            if (n > 100) begin
                checks++;
                failures++;
                $display("FAIL done_timeout: got %0d rsp / %0d beats pending expected 0",
                         exp_rsp.size(), exp_beat.size());
                exp_rsp.delete();
                exp_beat.delete();
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial #500000 begin
        $display("FAIL watchdog: got no finish expected finish before 500us");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        checks = 0; failures = 0; cyc = 0; acc_cyc = 0;
        in_beat = 0; rd_pending = 0; no_auto_rv = 0; force_rv = 0; stall_cnt = 0; rd_next = 0;
        rst = 1'b1;
        bus.req_valid = 1'b0; bus.req_store = 1'b0; bus.req_funct3 = 3'b0;
        bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_mem_req", {31'h0, bus.mem_req}, 32'h0);
        chk("rst_mem_we", {31'h0, bus.mem_we}, 32'h0);
        chk("rst_rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);
        chk("rst_rsp_err", {31'h0, bus.rsp_err}, 32'h0);
        chk("rst_mem_wstrb", {28'h0, bus.mem_wstrb}, 32'h0);
        chk("rst_mem_addr", bus.mem_addr, 32'h0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
        chk("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
        chk("rst_req_ready", {31'h0, bus.req_ready}, 32'h1);
        @(posedge clk);
        #1;

        // lw aligned
        exp_beat.push_back('{1'b0, 32'h1000, 32'h0, 4'b0000});
        rd_q.push_back(32'hDEAD_BEEF);
        issue(1'b0, 3'b010, 32'h1000, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b0, 3);
        wait_done();
        // lb / lbu, byte lane 2
        exp_beat.push_back('{1'b0, 32'h3000, 32'h0, 4'b0000});
        rd_q.push_back(32'h00F0_0000);
        issue(1'b0, 3'b000, 32'h3002, 32'h0, 1'b1, 32'hFFFF_FFF0, 1'b0, 3);
        wait_done();
        exp_beat.push_back('{1'b0, 32'h3000, 32'h0, 4'b0000});
        rd_q.push_back(32'h00F0_0000);
        issue(1'b0, 3'b100, 32'h3002, 32'h0, 1'b1, 32'h0000_00F0, 1'b0, 3);
        wait_done();
        // lh negative, upper half
        exp_beat.push_back('{1'b0, 32'h5000, 32'h0, 4'b0000});
        rd_q.push_back(32'h8001_7FFF);
        issue(1'b0, 3'b001, 32'h5002, 32'h0, 1'b1, 32'hFFFF_8001, 1'b0, 3);
        wait_done();
        // lhu split across words
        exp_beat.push_back('{1'b0, 32'h2000, 32'h0, 4'b0000});
        exp_beat.push_back('{1'b0, 32'h2004, 32'h0, 4'b0000});
        rd_q.push_back(32'h1122_3344);
        rd_q.push_back(32'h5566_7788);
        issue(1'b0, 3'b101, 32'h2003, 32'h0, 1'b1, 32'h0000_8811, 1'b0, 5);
        wait_done();
        // sw split with two stall cycles on beat0
        stall_cnt = 2;
        exp_beat.push_back('{1'b1, 32'h1000, 32'hBBCC_DD00, 4'b1110});
        exp_beat.push_back('{1'b1, 32'h1004, 32'h0000_00AA, 4'b0001});
        issue(1'b1, 3'b010, 32'h1001, 32'hAABB_CCDD, 1'b1, 32'h0, 1'b0, 5);
        wait_done();
        // sb top lane, sh upper half (not split: off+size == 4)
        exp_beat.push_back('{1'b1, 32'h4000, 32'h7800_0000, 4'b1000});
        issue(1'b1, 3'b000, 32'h4003, 32'h1234_5678, 1'b1, 32'h0, 1'b0, 2);
        wait_done();
        exp_beat.push_back('{1'b1, 32'h4000, 32'hBEEF_0000, 4'b1100});
        issue(1'b1, 3'b001, 32'h4002, 32'hCAFE_BEEF, 1'b1, 32'h0, 1'b0, 2);
        wait_done();
        // lw split wrapping past the top of the address space
        exp_beat.push_back('{1'b0, 32'hFFFF_FFFC, 32'h0, 4'b0000});
        exp_beat.push_back('{1'b0, 32'h0000_0000, 32'h0, 4'b0000});
        rd_q.push_back(32'hAABB_CCDD);
        rd_q.push_back(32'h1122_3344);
        issue(1'b0, 3'b010, 32'hFFFF_FFFE, 32'h0, 1'b1, 32'h3344_AABB, 1'b0, 5);
        wait_done();
        // illegal load and store funct3: no bus activity
        issue(1'b0, 3'b110, 32'h0000_0010, 32'h0, 1'b1, 32'h0, 1'b1, 1);
        wait_done();
        issue(1'b1, 3'b011, 32'h0000_0020, 32'hFFFF_FFFF, 1'b1, 32'h0, 1'b1, 1);
        wait_done();

        // reset while waiting for read data, then a late rvalid
        no_auto_rv = 1'b1;
        exp_beat.push_back('{1'b0, 32'h1000, 32'h0, 4'b0000});
        issue(1'b0, 3'b010, 32'h1000, 32'h0, 1'b0, 32'h0, 1'b0, 0);
        n = 0;
        while ((exp_beat.size() != 0 || in_beat) && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        force_rv = 1'b1;
        @(negedge clk);
        chk("rstmid_mem_req", {31'h0, bus.mem_req}, 32'h0);
        chk("rstmid_req_ready", {31'h0, bus.req_ready}, 32'h1);
        @(posedge clk);
        #1 force_rv = 1'b0;
        no_auto_rv = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("rstmid_no_rsp", {31'h0, bus.rsp_valid}, 32'h0);
            chk("rstmid_idle_mem_req", {31'h0, bus.mem_req}, 32'h0);
        end
        @(posedge clk);
        #1;
        exp_beat.push_back('{1'b0, 32'h0000_0008, 32'h0, 4'b0000});
        rd_q.push_back(32'h0BAD_F00D);
        issue(1'b0, 3'b010, 32'h0000_0008, 32'h0, 1'b1, 32'h0BAD_F00D, 1'b0, 3);
        wait_done();

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
